// File: rtl/rf_pkg.sv
// rf_pkg: shared types, byte-addressing constants and the write-merge helper for register_file_mp.
package rf_pkg;
  localparam int NUM_REGS_DEF = 8;
  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_idx_t;
  localparam int BYTE_HI_BIT = 2;
  localparam logic [2:0] BYTE_REG_MASK = 3'b011;
  localparam int MAX_WIDTH = 64;
  typedef logic [MAX_WIDTH-1:0] word_t;
  function automatic word_t merge_write(word_t old, word_t wv, logic is8, logic hi);
    word_t m;
    m = old;
    if (!is8) return wv;
    if (hi) m[15:8] = wv[7:0];
    else m[7:0] = wv[7:0];
    return m;
  endfunction
endpackage

// File: rtl/register_file_rd_port.sv
// register_file_rd_port: one registered read port; selects from the post-write array and extracts bytes.
module register_file_rd_port
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH = 16,
  parameter int SW = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS-1:0][WIDTH-1:0] nxt,
  input  logic [NUM_REGS-1:0]            busy_nxt,
  input  logic [SW-1:0]                  sel,
  input  logic                           is_8_bit,
  output logic [WIDTH-1:0]               val,
  output logic                           busy
);
  localparam int IW = $clog2(NUM_REGS);
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] w, val_d;
  logic [7:0] byte_v;
  always_comb begin
    idx = is_8_bit ? IW'(sel[2:0] & BYTE_REG_MASK) : sel[IW-1:0];
    w = nxt[idx];
    byte_v = sel[BYTE_HI_BIT] ? w[15:8] : w[7:0];
    val_d = is_8_bit ? WIDTH'(byte_v) : w;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val <= '0;
      busy <= 1'b0;
    end else begin
      val <= val_d;
      busy <= busy_nxt[idx];
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port GPR file with byte access, write-first bypass and
// optional busy scoreboard (enabled by RF_SCOREBOARD_EN).
module register_file_mp
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH = 16,
  parameter int NUM_RD_PORTS = 2,
  localparam int IW = $clog2(NUM_REGS),
  localparam int SW = (IW < 3) ? 3 : IW
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_RD_PORTS-1:0][SW-1:0]    rd_sel,
  input  logic [NUM_RD_PORTS-1:0]            rd_is_8_bit,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_val,
  output logic [NUM_RD_PORTS-1:0]            rd_busy,
  input  logic [SW-1:0]                      wr_sel,
  input  logic                               wr_is_8_bit,
  input  logic [WIDTH-1:0]                   wr_val,
  input  logic                               wr_en,
  input  logic                               reserve_en,
  input  logic [SW-1:0]                      reserve_sel,
  input  logic                               flush
);
  logic [NUM_REGS-1:0][WIDTH-1:0] regs, nxt;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [IW-1:0] wr_idx;
  always_comb begin
    wr_idx = wr_is_8_bit ? IW'(wr_sel[2:0] & BYTE_REG_MASK) : wr_sel[IW-1:0];
    for (int i = 0; i < NUM_REGS; i++)
      nxt[i] = (wr_en && wr_idx == IW'(i))
        ? WIDTH'(merge_write(word_t'(regs[i]), word_t'(wr_val), wr_is_8_bit, wr_sel[BYTE_HI_BIT]))
        : regs[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs <= '0;
    else regs <= nxt;
  end
`ifdef RF_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  // reserve is ORed after the write clear so a same-cycle reserve wins
  always_comb
    busy_nxt = flush ? '0
      : (busy & ~(wr_en ? (NUM_REGS'(1) << wr_idx) : '0))
        | (reserve_en ? (NUM_REGS'(1) << reserve_sel[IW-1:0]) : '0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else busy <= busy_nxt;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{reserve_en, reserve_sel, flush};
  assign busy_nxt = '0;
`endif
  genvar p;
  generate
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      register_file_rd_port #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .SW(SW)) u_rd (
        .clk(clk),
        .reset(reset),
        .nxt(nxt),
        .busy_nxt(busy_nxt),
        .sel(rd_sel[p]),
        .is_8_bit(rd_is_8_bit[p]),
        .val(rd_val[p]),
        .busy(rd_busy[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed plus random scoreboard bench for register_file_mp.
module tb_register_file_mp;
  import rf_pkg::*;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0][2:0] rd_sel;
  logic [1:0] rd_is_8_bit;
  logic [1:0][15:0] rd_val;
  logic [1:0] rd_busy;
  logic [2:0] wr_sel, reserve_sel;
  logic wr_is_8_bit, wr_en, reserve_en, flush;
  logic [15:0] wr_val;
  typedef struct {
    string tag;
    int port;
    logic [15:0] val;
    logic busy;
  } exp_t;
  exp_t q[$];
  logic [15:0] mem[8];
  logic [7:0] bsy;
  int vectors = 0;
  int miscompares = 0;

  register_file_mp dut (
    .clk(clk),
    .reset(reset),
    .rd_sel(rd_sel),
    .rd_is_8_bit(rd_is_8_bit),
    .rd_val(rd_val),
    .rd_busy(rd_busy),
    .wr_sel(wr_sel),
    .wr_is_8_bit(wr_is_8_bit),
    .wr_val(wr_val),
    .wr_en(wr_en),
    .reserve_en(reserve_en),
    .reserve_sel(reserve_sel),
    .flush(flush)
  );

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_is_8_bit = 0; wr_sel = 0; wr_val = 0;
    reserve_en = 0; reserve_sel = 0; flush = 0;
    rd_sel = '0; rd_is_8_bit = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    bsy = '0;
    q.delete();
  endtask

  // model the post-write state, queue expected reads, then clock and compare
  task automatic step(string tag);
    logic [15:0] mn[8];
    logic [7:0] bn;
    logic [2:0] t;
    logic [15:0] w;
    exp_t e;
    mn = mem;
    bn = bsy;
    if (wr_en) begin
      t = wr_is_8_bit ? {1'b0, wr_sel[1:0]} : wr_sel;
      if (!wr_is_8_bit) mn[t] = wr_val;
      else if (wr_sel[2]) mn[t][15:8] = wr_val[7:0];
      else mn[t][7:0] = wr_val[7:0];
      bn[t] = 1'b0;
    end
    if (reserve_en) bn[reserve_sel] = 1'b1;
    if (flush) bn = '0;
    if (!SB) bn = '0;
    for (int p = 0; p < 2; p++) begin
      t = rd_is_8_bit[p] ? {1'b0, rd_sel[p][1:0]} : rd_sel[p];
      w = mn[t];
      e.tag = $sformatf("%s p%0d", tag, p);
      e.port = p;
      e.val = rd_is_8_bit[p] ? {8'h00, rd_sel[p][2] ? w[15:8] : w[7:0]} : w;
      e.busy = bn[t];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    mem = mn;
    bsy = bn;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, " val"}, rd_val[e.port], e.val);
      chk({e.tag, " busy"}, {15'b0, rd_busy[e.port]}, {15'b0, e.busy});
    end
  endtask

  initial begin
    idle();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset val0", rd_val[0], 16'h0);
    chk("reset val1", rd_val[1], 16'h0);
    chk("reset busy", {14'b0, rd_busy}, 16'h0);
    reset = 0;
    for (int r = 0; r < 8; r++) begin
      rd_sel[0] = 3'(r);
      rd_sel[1] = 3'(7 - r);
      step("t1 read");
    end
    idle();
    wr_en = 1; wr_sel = 0; wr_val = 16'h1234;
    step("t2 wr");
    idle();
    rd_sel[0] = 3'b100; rd_is_8_bit[0] = 1;
    rd_sel[1] = 3'b000; rd_is_8_bit[1] = 1;
    step("t2 rd");
    chk("t2 AH", rd_val[0], 16'h0012);
    chk("t2 AL", rd_val[1], 16'h0034);
    idle();
    wr_en = 1; wr_is_8_bit = 1; wr_sel = 3'b100; wr_val = 16'h77AB;
    step("t3 bypass");
    chk("t3 bypass AX", rd_val[0], 16'hAB34);
    idle();
    step("t3 hold");
    chk("t3 hold AX", rd_val[0], 16'hAB34);
    reserve_en = 1; reserve_sel = 3;
    step("t4 reserve");
    idle();
    rd_sel[0] = 3; rd_sel[1] = 3'b111; rd_is_8_bit[1] = 1;
    step("t4 busy");
    chk("t4 busy", {15'b0, rd_busy[0]}, {15'b0, SB});
    chk("t4 busy8", {15'b0, rd_busy[1]}, {15'b0, SB});
    wr_en = 1; wr_sel = 3; wr_val = 16'h5555;
    step("t4 wb");
    chk("t4 wb val", rd_val[0], 16'h5555);
    chk("t4 wb busy", {15'b0, rd_busy[0]}, 16'h0);
    idle();
    reserve_en = 1; reserve_sel = 1; wr_en = 1; wr_sel = 1; wr_val = 16'h1111;
    rd_sel[0] = 1;
    step("t5 res+wr");
    chk("t5 res+wr busy", {15'b0, rd_busy[0]}, {15'b0, SB});
    idle();
    flush = 1; reserve_en = 1; reserve_sel = 2;
    rd_sel[0] = 2; rd_sel[1] = 1;
    step("t5 flush");
    chk("t5 flush busy", {14'b0, rd_busy}, 16'h0);
    idle();
    for (int n = 0; n < 80; n++) begin
      wr_en = 1'($urandom);
      wr_is_8_bit = 1'($urandom);
      wr_sel = 3'($urandom);
      wr_val = 16'($urandom);
      reserve_en = 1'($urandom);
      reserve_sel = 3'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      rd_sel[0] = 3'($urandom);
      rd_sel[1] = 3'($urandom);
      rd_is_8_bit = 2'($urandom);
      step("rand");
    end
    idle();
    wr_en = 1; wr_sel = 5; wr_val = 16'hFFFF;
    step("t6 wr");
    idle();
    rd_sel[0] = 5; rd_sel[1] = 5;
    step("t6 rd");
    chk("t6 pre", rd_val[0], 16'hFFFF);
    #2 reset = 1;
    #1;
    chk("t6 async val0", rd_val[0], 16'h0);
    chk("t6 async val1", rd_val[1], 16'h0);
    chk("t6 async busy", {14'b0, rd_busy}, 16'h0);
    clear_model();
    reset = 0;
    step("t6 post");
    chk("t6 post val", rd_val[0], 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
endmodule
